instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart of the control-path opcode decoder: turns structured instruction requests (kind, registers, funct fields, immediate) into 32-bit RV32I instruction words.
- Encoded words are buffered in a small FIFO, then written sequentially into instruction memory through a ready-qualified write port.
- Used by the self-test/boot path to build programs in instruction memory without a hex file.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
ADDR_W, 32, instruction memory address width
BASE_ADDR, 0, first write address after reset/clear

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush: empty FIFO, addr<=BASE_ADDR, clear imm_err
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when req_valid&&req_ready
req_kind  in  3  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 JALR
req_funct3  in  3  funct3 field
req_funct7b5  in  1  bit 30 (SUB/SRA/SRAI select)
req_rd  in  5  destination register
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_imm  in  32  signed byte-offset/immediate (LUI: full upper value)
imem_we  out  1  write strobe
imem_ready  in  1  memory accepts write this cycle
imem_addr  out  ADDR_W  write byte address
imem_wdata  out  32  encoded instruction
busy  out  1  FIFO not empty
imm_err  out  1  sticky: a request was dropped for an illegal immediate
wr_count  out  16  instructions written since reset/clear (saturates at 0xFFFF)

Behaviour:
- Reset (rst_n low, async): FIFO empty, imem_we=0, imem_wdata=0, imem_addr=BASE_ADDR, imm_err=0, wr_count=0, busy=0. req_ready may assert in the first cycle after release.
- Opcodes per kind: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111, 1100111.
- Encoding (pure function, computed at acceptance):
  - R: {0,funct7b5,00000,rs2,rs1,f3,rd,op}.
  - I-ALU: {imm[11:0],rs1,f3,rd,op}. Exception for f3=001/101: {0,funct7b5,00000,imm[4:0],rs1,f3,rd,op}.
  - LOAD: {imm[11:0],rs1,f3,rd,op}.
  - JALR: {imm[11:0],rs1,f3,rd,op}, with f3 forced to 000.
  - STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - LUI: {imm[31:12],rd,op}.
- Immediate legality (illegal -> request consumed, not enqueued, imm_err<=1):
  - I-ALU/LOAD/STORE/JALR: imm fits signed 12-bit.
  - Shift immediates: imm[31:5]==0.
  - BRANCH: fits signed 13-bit and imm[0]==0.
  - JAL: fits signed 21-bit and imm[0]==0.
  - LUI: imm[11:0]==0.
- Handshake and FIFO:
  - req_ready = !full && !clear. No combinational bypass.
  - An accepted word is visible on imem_wdata with imem_we=1 no earlier than the next cycle.
  - imem_we = !empty. imem_wdata/imem_addr come from the FIFO head and stay stable while imem_we && !imem_ready.
  - On imem_we && imem_ready: pop, imem_addr += 4 (wraps mod 2^ADDR_W), wr_count++.
  - Push and pop in the same cycle: occupancy unchanged. When full, a pop frees space but req_ready only rises the next cycle.
- clear has priority over push and pop: no write is counted in that cycle, and the request presented is not accepted.
- Reset asserted mid-stream discards FIFO contents immediately.

Test Plan:
- Reset, then I-ALU rd=1 rs1=0 f3=0 imm=5, imem_ready=1 -> next cycle imem_we=1, addr=0, wdata=0x00500093; wr_count=1 after.
- Back-to-back R sub (rd3,rs1=1,rs2=2,funct7b5=1), STORE f3=010 rs1=1 rs2=2 imm=8, JAL rd=1 imm=8, LUI rd=5 imm=0x12345000 -> 0x402081B3, 0x0020A423, 0x008000EF, 0x123452B7 at addr 0,4,8,C.
- imem_ready=0 while 6 requests are offered -> 4 accepted, req_ready=0; then release imem_ready -> words written in order, the remaining 2 accepted later, wr_count=6.
- BRANCH imm=3, then JAL imm=0x100000 -> both dropped, imm_err=1, no imem_we; a following legal request is still written at addr 0.
- FIFO holding 3 entries, then clear pulse -> busy=0, imm_err=0, addr=BASE_ADDR, wr_count=0; rst_n pulsed low mid-write -> imem_we drops asynchronously.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bundle for the instruction encoder/loader.
// No logic: the master drives requests and imem_ready, the slave answers them.
// Flow control is valid/ready on the request side and ready-qualified writes on imem.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [2:0]        req_funct3;
  logic              req_funct7b5;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_kind, req_funct3, req_funct7b5, req_rd, req_rs1, req_rs2,
           req_imm, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_funct3, req_funct7b5, req_rd, req_rs1, req_rs2,
           req_imm, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes structured RV32I requests into instruction words and writes them to imem in order.
// Latency: an accepted word appears on the imem write port one cycle after acceptance at the earliest.
// Backpressure: req_ready drops when the FIFO is full or clear is high; imem_ready stalls the head.
module instr_encoder_loader #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  instr_encoder_loader_if.slave       bus,
  output logic                        busy,
  output logic                        imm_err,
  output logic [15:0]                 wr_count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [ADDR_W-1:0] addr;
  logic              empty;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;
  logic              legal;
  logic [31:0]       word;

  // Shorthands for the request fields
  logic [31:0] imm;
  logic [2:0]  f3;
  logic        f7b5;
  logic [4:0]  rd, rs1, rs2;
  assign imm  = bus.req_imm;
  assign f3   = bus.req_funct3;
  assign f7b5 = bus.req_funct7b5;
  assign rd   = bus.req_rd;
  assign rs1  = bus.req_rs1;
  assign rs2  = bus.req_rs2;

  // Signed-range checks: all bits above the field's sign bit must equal it
  logic fits12, fits13, fits21;
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  // Instruction encoding and immediate legality, evaluated on the presented request
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (bus.req_kind)
      3'd0: word = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      3'd1: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shifts carry a 5-bit shamt; bit 30 selects arithmetic right shift
          word  = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
          legal = ~(|imm[31:5]);
        end else begin
          word  = {imm[11:0], rs1, f3, rd, 7'b0010011};
          legal = fits12;
        end
      end
      3'd2: begin
        word  = {imm[11:0], rs1, f3, rd, 7'b0000011};
        legal = fits12;
      end
      3'd3: begin
        word  = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
        legal = fits12;
      end
      3'd4: begin
        word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
        legal = fits13 & ~imm[0];
      end
      3'd5: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        legal = fits21 & ~imm[0];
      end
      3'd6: begin
        word  = {imm[31:12], rd, 7'b0110111};
        legal = ~(|imm[11:0]);
      end
      default: begin
        // JALR only has the funct3=000 form
        word  = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
        legal = fits12;
      end
    endcase
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign bus.req_ready  = ~full & ~clear;
  assign accept         = bus.req_valid & bus.req_ready;
  assign push           = accept & legal;
  assign pop            = bus.imem_we & bus.imem_ready & ~clear;

  assign bus.imem_we    = ~empty;
  assign bus.imem_wdata = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  assign bus.imem_addr  = addr;
  assign busy           = ~empty;

  // FIFO storage: written only on push, contents are don't-care while not valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= word;
    end
  end

  // FIFO pointers; clear and reset both empty the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Write address and saturating written-instruction count advance on each completed write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= BASE_ADDR;
      wr_count <= '0;
    end else if (clear) begin
      addr     <= BASE_ADDR;
      wr_count <= '0;
    end else if (pop) begin
      addr <= addr + ADDR_W'(4);
      if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

  // Sticky flag for requests consumed but dropped because of an illegal immediate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_err <= 1'b0;
    end else if (clear) begin
      imm_err <= 1'b0;
    end else if (accept && !legal) begin
      imm_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected words queued at acceptance, checked at write.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// A watchdog bounds the whole run.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        busy;
  logic        imm_err;
  logic [15:0] wr_count;

  instr_encoder_loader_if #(.ADDR_W(32)) bus ();

  instr_encoder_loader #(
    .DEPTH(4),
    .ADDR_W(32),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .bus(bus),
    .busy(busy),
    .imm_err(imm_err),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          accepted = 0;
  int          n_wr = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every completed write must match the oldest accepted legal request
  always @(negedge clk) begin
    logic [31:0] w;
    if (!rst_n || clear) begin
      sb.delete();
      exp_addr = 32'h0;
      n_wr = 0;
    end else if (bus.imem_we && bus.imem_ready) begin
      check_eq("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check_eq("wdata", bus.imem_wdata, w);
        check_eq("addr", bus.imem_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        n_wr++;
      end
    end
  end

  // Present one request and hold it until accepted; entered and left 1ns after a rising edge
  task automatic send(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit ok, input logic [31:0] w);
    int budget;
    bit done;
    budget = 100;
    done = 0;
    bus.req_valid    = 1'b1;
    bus.req_kind     = k;
    bus.req_funct3   = f3;
    bus.req_funct7b5 = f7;
    bus.req_rd       = rd;
    bus.req_rs1      = rs1;
    bus.req_rs2      = rs2;
    bus.req_imm      = imm;
    while (!done) begin
      @(negedge clk);
      if (bus.req_ready) begin
        if (ok) sb.push_back(w);
        accepted++;
        done = 1;
      end else begin
        budget--;
        if (budget == 0) begin
          check_eq("req_accept_timeout", 32'(bus.req_ready), 32'd1);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
  endtask

  // Wait for every queued word to be written, bounded
  task automatic drain();
    int b;
    b = 200;
    while ((sb.size() != 0 || busy) && b > 0) begin
      @(posedge clk);
      #1;
      b--;
    end
    check_eq("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    check_eq("clear_blocks_req", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [11:0] imm);
    addi_word = {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_kind = '0;
    bus.req_funct3 = '0;
    bus.req_funct7b5 = 1'b0;
    bus.req_rd = '0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.req_imm = '0;
    bus.imem_ready = 1'b0;

    // Reset values
    #12;
    check_eq("rst_we", 32'(bus.imem_we), 32'd0);
    check_eq("rst_wdata", bus.imem_wdata, 32'h0);
    check_eq("rst_addr", bus.imem_addr, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_imm_err", 32'(imm_err), 32'd0);
    check_eq("rst_wr_count", 32'(wr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single addi, visible on the write port the cycle after acceptance
    bus.imem_ready = 1'b1;
    send(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h00500093);
    check_eq("t1_we", 32'(bus.imem_we), 32'd1);
    check_eq("t1_addr", bus.imem_addr, 32'h0);
    check_eq("t1_wdata", bus.imem_wdata, 32'h00500093);
    drain();
    check_eq("t1_wr_count", 32'(wr_count), 32'd1);

    // Back-to-back mix of formats, including range boundaries and forced JALR funct3
    send(3'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3);
    send(3'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1, 32'h0020A423);
    send(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1, 32'h008000EF);
    send(3'd6, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1, 32'h123452B7);
    send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1, 32'h00208463);
    send(3'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd4, 1, 32'hFE000EE3);
    send(3'd1, 3'b001, 1'b0, 5'd5, 5'd6, 5'd0, 32'd3, 1, 32'h00331293);
    send(3'd1, 3'b101, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1, 32'h40335293);
    send(3'd7, 3'b011, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 1, 32'h00008067);
    send(3'd2, 3'b010, 1'b0, 5'd2, 5'd1, 5'd0, -32'sd4, 1, 32'hFFC0A103);
    send(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2047, 1, 32'h7FF00093);
    send(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, -32'sd2048, 1, 32'h80000093);
    // Illegal immediates: consumed without a write
    send(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 32'h0);
    send(3'd1, 3'b001, 1'b0, 5'd1, 5'd0, 5'd0, 32'd32, 0, 32'h0);
    send(3'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00001001, 0, 32'h0);
    drain();
    check_eq("t2_wr_count", 32'(wr_count), 32'd13);
    check_eq("t2_addr", bus.imem_addr, 32'd52);
    check_eq("t2_imm_err", 32'(imm_err), 32'd1);

    // Stalled memory: FIFO fills at DEPTH, drains in order when released
    do_clear();
    check_eq("t3_imm_err_cleared", 32'(imm_err), 32'd0);
    bus.imem_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(3'd1, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 10), 1,
               addi_word(5'(i + 1), 12'(i + 10)));
        end
      end
      begin
        repeat (8) @(negedge clk);
        check_eq("t3_accepted_full", 32'(accepted), 32'd4);
        check_eq("t3_ready_full", 32'(bus.req_ready), 32'd0);
        check_eq("t3_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        bus.imem_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_ready_lags_pop", 32'(bus.req_ready), 32'd0);
      end
    join
    drain();
    check_eq("t3_accepted_all", 32'(accepted), 32'd6);
    check_eq("t3_wr_count", 32'(wr_count), 32'd6);
    check_eq("t3_wr_count_sb", 32'(wr_count), 32'(n_wr));
    check_eq("t3_addr", bus.imem_addr, 32'd24);

    // Dropped branch/jal immediates, then a legal write still lands at the base address
    do_clear();
    send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 0, 32'h0);
    send(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00100000, 0, 32'h0);
    @(posedge clk);
    #1;
    check_eq("t4_imm_err", 32'(imm_err), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_we", 32'(bus.imem_we), 32'd0);
    send(3'd1, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1, 32'h00700113);
    drain();
    check_eq("t4_addr", bus.imem_addr, 32'd4);
    check_eq("t4_wr_count", 32'(wr_count), 32'd1);

    // Clear flushes a partly filled FIFO
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i), 1, addi_word(5'd1, 12'(i)));
    end
    check_eq("t5_busy_before", 32'(busy), 32'd1);
    do_clear();
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_imm_err", 32'(imm_err), 32'd0);
    check_eq("t5_addr", bus.imem_addr, 32'h0);
    check_eq("t5_wr_count", 32'(wr_count), 32'd0);
    check_eq("t5_we", 32'(bus.imem_we), 32'd0);

    // Asynchronous reset mid-stream drops the write strobe without a clock edge
    for (int i = 0; i < 2; i++) begin
      send(3'd1, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'(i), 1, addi_word(5'd4, 12'(i)));
    end
    check_eq("t6_we_before", 32'(bus.imem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_we_async", 32'(bus.imem_we), 32'd0);
    check_eq("t6_busy_async", 32'(busy), 32'd0);
    check_eq("t6_addr_async", bus.imem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.imem_ready = 1'b1;
    send(3'd1, 3'b000, 1'b0, 5'd9, 5'd0, 5'd0, 32'd1, 1, addi_word(5'd9, 12'd1));
    drain();
    check_eq("t6_wr_count", 32'(wr_count), 32'd1);
    check_eq("t6_addr", bus.imem_addr, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
